// File: rtl/alu_seq_exec.sv
`default_nettype none
// ============================================================================
//  Module      : alu_seq_exec
//  Description : Single-request ALU with a valid/ready handshake on both sides.
//                Logic and arithmetic ops complete one cycle after the transfer.
//                Shift ops (SLL/SRL/SRA, amount = SrcB[4:0]) are done one bit
//                per cycle in state SHIFT. With ALU_SEQ_BARREL_SHIFT_EN
//                defined they are done in a single cycle instead. Results are
//                the same in both builds.
//  Ports       : clk        - rising-edge clock
//                rst_n      - asynchronous active-low reset
//                in_valid   - request valid
//                in_ready   - high only in IDLE
//                Operation  - 4-bit ALU op code
//                SrcA/SrcB  - operands (DATA_W bits)
//                out_valid  - result valid, held until out_ready
//                out_ready  - consumer accepts result
//                ALUResult  - registered result
//                Zero       - registered zero flag (A == B for BEQ)
//  Config      : `define ALU_SEQ_BARREL_SHIFT_EN -> single-cycle shifts
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_seq_exec #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        Operation,
    input  logic [DATA_W-1:0] SrcA,
    input  logic [DATA_W-1:0] SrcB,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] ALUResult,
    output logic              Zero
);

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_SHIFT = 2'd1;
    localparam logic [1:0] c_ST_DONE  = 2'd2;

    localparam logic [3:0] c_OP_AND = 4'b0000;
    localparam logic [3:0] c_OP_OR  = 4'b0001;
    localparam logic [3:0] c_OP_ADD = 4'b0010;
    localparam logic [3:0] c_OP_SUB = 4'b0011;
    localparam logic [3:0] c_OP_SRL = 4'b0101;
    localparam logic [3:0] c_OP_SLL = 4'b0110;
    localparam logic [3:0] c_OP_SRA = 4'b0111;
    localparam logic [3:0] c_OP_BEQ = 4'b1000;
    localparam logic [3:0] c_OP_SLT = 4'b1100;

    // Low two op bits distinguish the shifts: 01 SRL, 10 SLL, 11 SRA.
    localparam logic [1:0] c_SH_SLL = 2'b10;
    localparam logic [1:0] c_SH_SRA = 2'b11;

    logic [1:0]        r_state;
    logic [1:0]        w_next_state;
    logic [DATA_W-1:0] r_result;
    logic              r_zero;
    logic [DATA_W-1:0] r_work;
    logic [4:0]        r_cnt;
    logic [1:0]        r_shift_op;
    logic [DATA_W-1:0] w_alu_result;
    logic              w_alu_zero;
    logic [DATA_W-1:0] w_work_shifted;
    logic              w_transfer;

    assign w_transfer = in_valid && (r_state == c_ST_IDLE);

    // ------------------------------------------------------------------
    // Single-cycle result, evaluated on the live inputs and captured on
    // the transfer edge. In the iterative build a shift op captures SrcA
    // here, which is already the answer for a zero shift amount; for a
    // non-zero amount the SHIFT state overwrites it.
    // ------------------------------------------------------------------
    always_comb begin
        w_alu_result = '0;
        case (Operation)
            c_OP_AND: w_alu_result = SrcA & SrcB;
            c_OP_OR:  w_alu_result = SrcA | SrcB;
            c_OP_ADD: w_alu_result = SrcA + SrcB;
            c_OP_SUB: w_alu_result = SrcA - SrcB;
            c_OP_BEQ: w_alu_result = SrcA - SrcB;
            c_OP_SLT: w_alu_result = {{(DATA_W-1){1'b0}}, ($signed(SrcA) < $signed(SrcB))};
`ifdef ALU_SEQ_BARREL_SHIFT_EN
            c_OP_SLL: w_alu_result = SrcA << SrcB[4:0];
            c_OP_SRL: w_alu_result = SrcA >> SrcB[4:0];
            c_OP_SRA: w_alu_result = DATA_W'($signed(SrcA) >>> SrcB[4:0]);
`else
            c_OP_SLL: w_alu_result = SrcA;
            c_OP_SRL: w_alu_result = SrcA;
            c_OP_SRA: w_alu_result = SrcA;
`endif
            default:  w_alu_result = '0;
        endcase
        w_alu_zero = (w_alu_result == '0);
        if (Operation == c_OP_BEQ) begin
            w_alu_zero = (SrcA == SrcB);
        end
    end

    // One-bit step of the iterative shifter.
    always_comb begin
        case (r_shift_op)
            c_SH_SLL: w_work_shifted = {r_work[DATA_W-2:0], 1'b0};
            c_SH_SRA: w_work_shifted = {r_work[DATA_W-1], r_work[DATA_W-1:1]};
            default:  w_work_shifted = {1'b0, r_work[DATA_W-1:1]};
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
`ifndef ALU_SEQ_BARREL_SHIFT_EN
    logic w_is_shift;
    assign w_is_shift = (Operation == c_OP_SLL) || (Operation == c_OP_SRL) ||
                        (Operation == c_OP_SRA);
`endif

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (in_valid) begin
`ifdef ALU_SEQ_BARREL_SHIFT_EN
                    w_next_state = c_ST_DONE;
`else
                    w_next_state = (w_is_shift && (SrcB[4:0] != 5'd0)) ? c_ST_SHIFT : c_ST_DONE;
`endif
                end
            end
            // The counter is never zero here; the step that takes it to
            // zero is the last one.
            c_ST_SHIFT: begin
                if (r_cnt == 5'd1) begin
                    w_next_state = c_ST_DONE;
                end
            end
            c_ST_DONE: begin
                if (out_ready) begin
                    w_next_state = c_ST_IDLE;
                end
            end
            default: w_next_state = c_ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        in_ready  = (r_state == c_ST_IDLE);
        out_valid = (r_state == c_ST_DONE);
    end

    assign ALUResult = r_result;
    assign Zero      = r_zero;

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_result   <= '0;
            r_zero     <= 1'b0;
            r_work     <= '0;
            r_cnt      <= 5'd0;
            r_shift_op <= 2'b00;
        end else begin
            if (w_transfer) begin
                r_result   <= w_alu_result;
                r_zero     <= w_alu_zero;
                r_work     <= SrcA;
                r_cnt      <= SrcB[4:0];
                r_shift_op <= Operation[1:0];
            end else if (r_state == c_ST_SHIFT) begin
                r_work <= w_work_shifted;
                r_cnt  <= r_cnt - 5'd1;
                if (r_cnt == 5'd1) begin
                    r_result <= w_work_shifted;
                    r_zero   <= (w_work_shifted == '0);
                end
            end
        end
    end

endmodule
`default_nettype wire
